// File: rtl/pipeline_defs.sv
// Shared pipeline definitions: stage FSM encoding, occupancy width and
// the packed payload structs that the pipeline stages hand to pipe_stage_skid.
package pipeline_defs;

   localparam int PIPE_OCC_W = 2;

   // Encoding doubles as the occupancy count (0 / 1 / 2 stored entries).
   typedef enum logic [PIPE_OCC_W-1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } pipe_state_t;

   // Stage payloads; each is packed to a flat vector by the instantiating stage.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } id_ex_t;

   typedef struct packed {
      logic [31:0] alu_res;
      logic [26:0] store_data;
      logic [4:0]  rd;
   } ex_mem_t;

   typedef struct packed {
      logic [31:0] wb_data;
      logic [26:0] rsvd;
      logic [4:0]  rd;
   } mem_wb_t;

   // Number of stored entries held in a given state.
   function automatic logic [PIPE_OCC_W-1:0] occ_of(input pipe_state_t s);
      return s;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc high and parks at all-ones.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v, input logic en);
      if (en && (v != {W{1'b1}})) begin
         return v + W'(1);
      end
      return v;
   endfunction

   // Next count: increment unless already saturated.
   always_comb begin
      count_d = sat_inc(count_q, inc);
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake, synchronous
// flush (bubble) and an optional 2-entry skid buffer that registers in_ready.
// Empty slots always hold zero so a bubble looks like an all-zero payload.
module pipe_stage_skid
   import pipeline_defs::*;
#(
   parameter int DATA_W  = 64,
   parameter int SKID_EN = 1,
   parameter int CNT_W   = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_data,
   output logic [PIPE_OCC_W-1:0] occupancy,
   output logic [CNT_W-1:0]      stall_cnt
);

   pipe_state_t       state_q;
   pipe_state_t       state_d;
   logic [DATA_W-1:0] main_q;
   logic [DATA_W-1:0] main_d;
   logic [DATA_W-1:0] skid_q;
   logic              in_fire;
   logic              stall_inc;

   assign in_fire   = in_valid && in_ready;
   assign stall_inc = out_valid && !out_ready;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; flush forces a bubble and drops any incoming payload.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: if (in_fire) state_d = BUSY;
            BUSY: begin
               if (out_ready) begin
                  if (!in_fire) state_d = EMPTY;
               end else if (in_fire) begin
                  state_d = FULL;
               end
            end
            FULL:    if (out_ready) state_d = BUSY;
            default: state_d = EMPTY;
         endcase
      end
   end

   // Outputs decoded from the registered state and head register.
   always_comb begin
      out_valid = (state_q != EMPTY);
      occupancy = occ_of(state_q);
      out_data  = main_q;
   end

   // Head register next value: load, refill from skid, or clear to a bubble.
   always_comb begin
      main_d = main_q;
      if (flush) begin
         main_d = '0;
      end else begin
         case (state_q)
            EMPTY: if (in_fire) main_d = in_data;
            BUSY: begin
               if (out_ready) main_d = in_fire ? in_data : '0;
            end
            FULL:    if (out_ready) main_d = skid_q;
            default: main_d = '0;
         endcase
      end
   end

   // Head register.
   always_ff @(posedge clk) begin
      if (reset) begin
         main_q <= '0;
      end else begin
         main_q <= main_d;
      end
   end

   generate
      if (SKID_EN != 0) begin : g_skid
         logic [DATA_W-1:0] skid_buf_q;
         logic [DATA_W-1:0] skid_buf_d;
         logic              rdy_q;
         logic              rdy_d;

         // Skid slot catches the beat accepted while downstream stalls.
         always_comb begin
            skid_buf_d = skid_buf_q;
            if (flush) begin
               skid_buf_d = '0;
            end else if ((state_q == BUSY) && !out_ready && in_fire) begin
               skid_buf_d = in_data;
            end else if ((state_q == FULL) && out_ready) begin
               skid_buf_d = '0;
            end
            rdy_d = (state_d != FULL);
         end

         // Skid slot and registered ready; ready never sees out_ready combinationally.
         always_ff @(posedge clk) begin
            if (reset) begin
               skid_buf_q <= '0;
               rdy_q      <= 1'b1;
            end else begin
               skid_buf_q <= skid_buf_d;
               rdy_q      <= rdy_d;
            end
         end

         assign skid_q   = skid_buf_q;
         assign in_ready = rdy_q;
      end else begin : g_noskid
         assign skid_q   = '0;
         assign in_ready = !out_valid || out_ready;
      end
   endgenerate

   sat_counter #(
      .W(CNT_W)
   ) u_stall_cnt (
      .clk  (clk),
      .reset(reset),
      .inc  (stall_inc),
      .count(stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: one skid-mode instance (4-bit stall
// counter) and one single-entry instance, each with its own scoreboard.
module tb_pipe_stage_skid;
   import pipeline_defs::*;

   logic clk;
   logic reset;

   logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [63:0] a_in_data, a_out_data;
   logic [1:0]  a_occupancy;
   logic [3:0]  a_stall_cnt;

   logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [63:0] b_in_data, b_out_data;
   logic [1:0]  b_occupancy;
   logic [31:0] b_stall_cnt;

   int total = 0;
   int bad   = 0;

   logic [63:0] a_exp_q[$];
   logic [63:0] b_exp_q[$];

   pipe_stage_skid #(.DATA_W(64), .SKID_EN(1), .CNT_W(4)) u_a (
      .clk(clk), .reset(reset), .flush(a_flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .occupancy(a_occupancy), .stall_cnt(a_stall_cnt)
   );

   pipe_stage_skid #(.DATA_W(64), .SKID_EN(0), .CNT_W(32)) u_b (
      .clk(clk), .reset(reset), .flush(b_flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .occupancy(b_occupancy), .stall_cnt(b_stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   // Monitor for instance A: pops on every output transfer, plus invariants.
   initial begin
      logic        prev_stall;
      logic [63:0] prev_data;
      logic [63:0] exp;
      prev_stall = 1'b0;
      prev_data  = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (a_out_valid && a_out_ready) begin
               if (a_exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL a_unexpected_out: got=0x%0h expected=none", a_out_data);
               end else begin
                  exp = a_exp_q.pop_front();
                  chk("a_out_order", a_out_data, exp);
               end
            end
            if (!a_out_valid) chk("a_idle_zero", a_out_data, 64'h0);
            total++;
            if (a_occupancy == 2'd3) begin
               bad++;
               $display("FAIL a_occ_range: got=%0d expected<=2", a_occupancy);
            end
            if (prev_stall) chk("a_hold_stable", a_out_data, prev_data);
         end
         prev_stall = a_out_valid && !a_out_ready && !a_flush && !reset;
         prev_data  = a_out_data;
      end
   end

   // Monitor for instance B.
   initial begin
      logic        prev_stall;
      logic [63:0] prev_data;
      logic [63:0] exp;
      prev_stall = 1'b0;
      prev_data  = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (b_out_valid && b_out_ready) begin
               if (b_exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL b_unexpected_out: got=0x%0h expected=none", b_out_data);
               end else begin
                  exp = b_exp_q.pop_front();
                  chk("b_out_order", b_out_data, exp);
               end
            end
            if (!b_out_valid) chk("b_idle_zero", b_out_data, 64'h0);
            total++;
            if (b_occupancy > 2'd1) begin
               bad++;
               $display("FAIL b_occ_range: got=%0d expected<=1", b_occupancy);
            end
            if (prev_stall) chk("b_hold_stable", b_out_data, prev_data);
         end
         prev_stall = b_out_valid && !b_out_ready && !b_flush && !reset;
         prev_data  = b_out_data;
      end
   end

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "bench timed out");
   end

   // Stimulus.
   initial begin
      reset = 1'b1;
      a_flush = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 1;
      b_flush = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 1;
      step(); step();
      reset = 1'b0;
      at_neg();
      chk("rst_a_out_valid", 64'(a_out_valid), 64'h0);
      chk("rst_a_out_data",  a_out_data, 64'h0);
      chk("rst_a_occ",       64'(a_occupancy), 64'h0);
      chk("rst_a_stall",     64'(a_stall_cnt), 64'h0);
      chk("rst_a_in_ready",  64'(a_in_ready), 64'h1);
      chk("rst_b_in_ready",  64'(b_in_ready), 64'h1);

      // Stream 1,2,3 with out_ready high.
      step(); a_in_valid = 1; a_in_data = 64'h1; a_exp_q.push_back(64'h1);
      at_neg(); chk("str_in_ready0", 64'(a_in_ready), 64'h1);
      step(); a_in_data = 64'h2; a_exp_q.push_back(64'h2);
      at_neg(); chk("str_data1", a_out_data, 64'h1); chk("str_in_ready1", 64'(a_in_ready), 64'h1);
      step(); a_in_data = 64'h3; a_exp_q.push_back(64'h3);
      at_neg(); chk("str_data2", a_out_data, 64'h2); chk("str_in_ready2", 64'(a_in_ready), 64'h1);
      step(); a_in_valid = 0;
      at_neg(); chk("str_data3", a_out_data, 64'h3);
      step();
      at_neg(); chk("str_empty", 64'(a_out_valid), 64'h0); chk("str_stall", 64'(a_stall_cnt), 64'h0);

      // Back-pressure: A then B into main and skid, hold, then drain.
      step(); a_out_ready = 0; a_in_valid = 1; a_in_data = 64'hA; a_exp_q.push_back(64'hA);
      at_neg();
      step(); a_in_data = 64'hB; a_exp_q.push_back(64'hB);
      at_neg(); chk("bp_in_ready_busy", 64'(a_in_ready), 64'h1);
      step(); a_in_valid = 0;
      at_neg(); chk("bp_occ2", 64'(a_occupancy), 64'h2); chk("bp_in_ready_full", 64'(a_in_ready), 64'h0);
      chk("bp_head", a_out_data, 64'hA);
      step();
      at_neg(); chk("bp_occ2_hold", 64'(a_occupancy), 64'h2);
      step(); a_out_ready = 1;
      at_neg();
      step();
      at_neg(); chk("bp_head_b", a_out_data, 64'hB); chk("bp_occ1", 64'(a_occupancy), 64'h1);
      chk("bp_in_ready_back", 64'(a_in_ready), 64'h1);
      step();
      at_neg(); chk("bp_stall3", 64'(a_stall_cnt), 64'h3); chk("bp_occ0", 64'(a_occupancy), 64'h0);

      // Flush while FULL with an incoming payload.
      step(); a_out_ready = 0; a_in_valid = 1; a_in_data = 64'h11; a_exp_q.push_back(64'h11);
      at_neg();
      step(); a_in_data = 64'h12; a_exp_q.push_back(64'h12);
      at_neg();
      step(); a_in_data = 64'hC; a_flush = 1; a_exp_q.delete();
      at_neg(); chk("fl_in_ready_full", 64'(a_in_ready), 64'h0);
      step(); a_flush = 0; a_in_valid = 0;
      at_neg(); chk("fl_out_valid", 64'(a_out_valid), 64'h0); chk("fl_out_data", a_out_data, 64'h0);
      chk("fl_occ", 64'(a_occupancy), 64'h0); chk("fl_stall_kept", 64'(a_stall_cnt), 64'h5);
      chk("fl_in_ready", 64'(a_in_ready), 64'h1);
      step(); a_out_ready = 1;
      at_neg(); step(); at_neg();

      // Flush while BUSY: in_ready is high but the incoming payload is dropped.
      step(); a_out_ready = 0; a_in_valid = 1; a_in_data = 64'h21; a_exp_q.push_back(64'h21);
      at_neg();
      step(); a_in_data = 64'h22; a_flush = 1; a_exp_q.delete();
      at_neg();
      step(); a_flush = 0; a_in_valid = 0;
      at_neg(); chk("flb_occ", 64'(a_occupancy), 64'h0); chk("flb_stall", 64'(a_stall_cnt), 64'h6);
      step(); a_out_ready = 1;
      at_neg(); chk("flb_dropped", 64'(a_out_valid), 64'h0);

      // Saturation of the 4-bit counter.
      step(); reset = 1;
      at_neg();
      step(); reset = 0;
      at_neg(); chk("sat_rst", 64'(a_stall_cnt), 64'h0);
      step(); a_out_ready = 0; a_in_valid = 1; a_in_data = 64'h31; a_exp_q.push_back(64'h31);
      at_neg();
      step(); a_in_valid = 0;
      repeat (10) step();
      at_neg(); chk("sat_10", 64'(a_stall_cnt), 64'd10);
      repeat (10) step();
      at_neg(); chk("sat_20", 64'(a_stall_cnt), 64'd15);
      repeat (5) step();
      at_neg(); chk("sat_25", 64'(a_stall_cnt), 64'd15);
      step(); a_out_ready = 1;
      at_neg();
      step();
      at_neg(); chk("sat_after", 64'(a_stall_cnt), 64'd15); chk("sat_empty", 64'(a_out_valid), 64'h0);

      // Reset while FULL, then a fresh push emerges after one cycle.
      step(); a_out_ready = 0; a_in_valid = 1; a_in_data = 64'h41; a_exp_q.push_back(64'h41);
      at_neg();
      step(); a_in_data = 64'h42; a_exp_q.push_back(64'h42);
      at_neg();
      step(); a_in_valid = 0;
      at_neg(); chk("mr_full", 64'(a_occupancy), 64'h2);
      step(); reset = 1; a_exp_q.delete();
      at_neg();
      step(); reset = 0;
      at_neg(); chk("mr_out_valid", 64'(a_out_valid), 64'h0); chk("mr_out_data", a_out_data, 64'h0);
      chk("mr_occ", 64'(a_occupancy), 64'h0); chk("mr_stall", 64'(a_stall_cnt), 64'h0);
      chk("mr_in_ready", 64'(a_in_ready), 64'h1);
      step(); a_out_ready = 1; a_in_valid = 1; a_in_data = 64'h5; a_exp_q.push_back(64'h5);
      at_neg();
      step(); a_in_valid = 0;
      at_neg(); chk("mr_lat_valid", 64'(a_out_valid), 64'h1); chk("mr_lat_data", a_out_data, 64'h5);
      step();
      at_neg(); chk("mr_drained", 64'(a_out_valid), 64'h0);

      // Single-entry mode: combinational in_ready.
      step(); b_out_ready = 0; b_in_valid = 1; b_in_data = 64'h61; b_exp_q.push_back(64'h61);
      at_neg(); chk("ns_in_ready_empty", 64'(b_in_ready), 64'h1);
      step(); b_in_data = 64'h62;
      #1; chk("ns_in_ready_stall", 64'(b_in_ready), 64'h0);
      at_neg(); chk("ns_occ1", 64'(b_occupancy), 64'h1);
      step(); b_out_ready = 1; b_exp_q.push_back(64'h62);
      #1; chk("ns_in_ready_comb", 64'(b_in_ready), 64'h1);
      at_neg();
      step(); b_in_data = 64'h63; b_exp_q.push_back(64'h63);
      at_neg(); chk("ns_data62", b_out_data, 64'h62); chk("ns_in_ready_b2b", 64'(b_in_ready), 64'h1);
      step(); b_in_data = 64'h64; b_exp_q.push_back(64'h64);
      at_neg(); chk("ns_data63", b_out_data, 64'h63);
      step(); b_in_valid = 0;
      at_neg(); chk("ns_data64", b_out_data, 64'h64);
      step();
      at_neg(); chk("ns_empty", 64'(b_out_valid), 64'h0); chk("ns_stall", b_stall_cnt, 64'h1);
      chk("ns_occ0", 64'(b_occupancy), 64'h0);

      step();
      chk("a_scoreboard_drained", 64'(a_exp_q.size()), 64'h0);
      chk("b_scoreboard_drained", 64'(b_exp_q.size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
